// File: rtl/mem_b_arbiter.sv
// rtl/mem_b_arbiter.sv - port-B arbiter for VGA fetch, SNES button mirror and CPU load/store
module mem_b_arbiter #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BTN_ADDR    = 'h3FF,
  parameter int unsigned MAX_VGA_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              btn_update,
  input  logic [11:0]       btn_data,
  output logic              btn_pending,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic [DATA_W-1:0] mem_data_b,
  output logic              mem_we_b,
  input  logic [DATA_W-1:0] mem_q_b
);

  localparam int unsigned       RUN_W   = $clog2(MAX_VGA_RUN + 1);
  localparam logic [ADDR_W-1:0] BTN_A   = ADDR_W'(BTN_ADDR);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_VGA_RUN);
  localparam logic              LOW_CPU = 1'b0;
  localparam logic              LOW_BTN = 1'b1;

  logic [RUN_W-1:0] vga_run_q, vga_run_d;
  logic             last_low_q, last_low_d;
  logic             btn_pending_q, btn_pending_d;
  logic [11:0]      btn_word_q, btn_word_d;
  logic             vga_rvalid_q, vga_rvalid_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;

  logic low_req;
  logic vga_win;
  logic cpu_win;
  logic btn_win;

  // Pick at most one winner: VGA first unless its run budget is spent while a low request waits
  always_comb begin
    low_req = cpu_req | btn_pending_q;
    vga_win = 1'b0;
    cpu_win = 1'b0;
    btn_win = 1'b0;
    if (reset) begin
      if (vga_req && !(low_req && (vga_run_q == RUN_MAX))) begin
        vga_win = 1'b1;
      end else if (cpu_req && btn_pending_q) begin
        if (last_low_q == LOW_CPU) begin
          btn_win = 1'b1;
        end else begin
          cpu_win = 1'b1;
        end
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end else if (btn_pending_q) begin
        btn_win = 1'b1;
      end
    end
  end

  // Steer the winner onto port B; an idle port drives all zeros
  always_comb begin
    mem_we_b   = 1'b0;
    mem_addr_b = '0;
    mem_data_b = '0;
    if (vga_win) begin
      mem_addr_b = vga_addr;
    end else if (cpu_win) begin
      mem_we_b   = cpu_we;
      mem_addr_b = cpu_addr;
      mem_data_b = cpu_wdata;
    end else if (btn_win) begin
      mem_we_b   = 1'b1;
      mem_addr_b = BTN_A;
      mem_data_b = DATA_W'(btn_word_q);
    end
  end

  // Next state: VGA run length, round-robin pointer, button mailbox, read-return flags
  always_comb begin
    vga_run_d = '0;
    if (vga_win) begin
      vga_run_d = (vga_run_q == RUN_MAX) ? RUN_MAX : vga_run_q + 1'b1;
    end
    last_low_d = last_low_q;
    if (cpu_win) begin
      last_low_d = LOW_CPU;
    end else if (btn_win) begin
      last_low_d = LOW_BTN;
    end
    // A fresh sample always wins over a same-cycle grant, which already used the old word
    btn_word_d    = btn_word_q;
    btn_pending_d = btn_pending_q;
    if (btn_update) begin
      btn_word_d    = btn_data;
      btn_pending_d = 1'b1;
    end else if (btn_win) begin
      btn_pending_d = 1'b0;
    end
    vga_rvalid_d = vga_win;
    cpu_rvalid_d = cpu_win & ~cpu_we;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      vga_run_q     <= '0;
      last_low_q    <= LOW_CPU;
      btn_pending_q <= 1'b0;
      btn_word_q    <= '0;
      vga_rvalid_q  <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
    end else begin
      vga_run_q     <= vga_run_d;
      last_low_q    <= last_low_d;
      btn_pending_q <= btn_pending_d;
      btn_word_q    <= btn_word_d;
      vga_rvalid_q  <= vga_rvalid_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
    end
  end

  // Grants and returns; rvalid is masked while reset is held so an in-flight read is dropped
  always_comb begin
    vga_gnt     = vga_win;
    cpu_gnt     = cpu_win;
    vga_rvalid  = vga_rvalid_q & reset;
    cpu_rvalid  = cpu_rvalid_q & reset;
    vga_rdata   = mem_q_b;
    cpu_rdata   = mem_q_b;
    btn_pending = btn_pending_q;
  end

endmodule

// File: tb/tb_mem_b_arbiter.sv
// tb/tb_mem_b_arbiter.sv - self-checking bench for mem_b_arbiter
module tb_mem_b_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          btn_update;
  logic [11:0]   btn_data;
  logic          btn_pending;
  logic [AW-1:0] mem_addr_b;
  logic [DW-1:0] mem_data_b;
  logic          mem_we_b;
  logic [DW-1:0] mem_q_b;

  always #5 clk = ~clk;

  mem_b_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BTN_ADDR('h3FF), .MAX_VGA_RUN(4)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .btn_update(btn_update), .btn_data(btn_data), .btn_pending(btn_pending),
    .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b), .mem_we_b(mem_we_b),
    .mem_q_b(mem_q_b)
  );

  logic [DW-1:0] mem     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (mem_we_b) mem[mem_addr_b] <= mem_data_b;
    mem_q_b <= mem[mem_addr_b];
  end

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] vga_q[$];
  logic [DW-1:0] cpu_q[$];

  typedef struct packed {
    logic          vreq;
    logic [AW-1:0] vaddr;
    logic          creq;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwdata;
    logic          bupd;
    logic [11:0]   bdata;
    logic          e_vgnt;
    logic          e_cgnt;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic vreq, input logic [AW-1:0] vaddr,
                              input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                              input logic [DW-1:0] cwdata, input logic bupd, input logic [11:0] bdata,
                              input logic e_vgnt, input logic e_cgnt, input logic e_we,
                              input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data,
                              input logic e_pend);
    vec_t v;
    v = '{vreq, vaddr, creq, cwe, caddr, cwdata, bupd, bdata,
          e_vgnt, e_cgnt, e_we, e_addr, e_data, e_pend};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Read-return scoreboard: every rvalid must match the oldest expected word
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (vga_rvalid === 1'b1) begin
        if (vga_q.size() == 0) begin
          check("vga_rvalid_unexpected", 1, 0);
        end else begin
          e = vga_q.pop_front();
          check("vga_rdata", vga_rdata, e);
        end
      end
      if (cpu_rvalid === 1'b1) begin
        if (cpu_q.size() == 0) begin
          check("cpu_rvalid_unexpected", 1, 0);
        end else begin
          e = cpu_q.pop_front();
          check("cpu_rdata", cpu_rdata, e);
        end
      end
    end
  end

  task automatic idle_inputs();
    vga_req = 0; vga_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0;
    cpu_wdata = '0; btn_update = 0; btn_data = '0;
  endtask

  initial begin
    int bw_count;
    logic ev;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'(i) ^ 16'h5A00;
      ref_mem[i] = 16'(i) ^ 16'h5A00;
    end
    mem[5] = 16'h1234;      ref_mem[5] = 16'h1234;
    mem[10'h010] = 16'h5A5A; ref_mem[10'h010] = 16'h5A5A;

    // test 3: single button write
    add(0,0,     0,0,0,0,       1,12'hA5F, 0,0,0,0,0,0);
    add(0,0,     0,0,0,0,       0,0,       0,0,1,10'h3FF,16'h0A5F,1);
    add(0,0,     0,0,0,0,       0,0,       0,0,0,0,0,0);
    // test 4: VGA run of four, then the waiting CPU read, then VGA resumes
    add(1,10'h100, 1,0,10'h010,0, 0,0,     1,0,0,10'h100,0,0);
    add(1,10'h101, 1,0,10'h010,0, 0,0,     1,0,0,10'h101,0,0);
    add(1,10'h102, 1,0,10'h010,0, 0,0,     1,0,0,10'h102,0,0);
    add(1,10'h103, 1,0,10'h010,0, 0,0,     1,0,0,10'h103,0,0);
    add(1,10'h104, 1,0,10'h010,0, 0,0,     0,1,0,10'h010,0,0);
    add(1,10'h104, 0,0,0,0,       0,0,     1,0,0,10'h104,0,0);
    add(1,10'h105, 0,0,0,0,       0,0,     1,0,0,10'h105,0,0);
    add(1,10'h106, 0,0,0,0,       0,0,     1,0,0,10'h106,0,0);
    add(1,10'h107, 0,0,0,0,       0,0,     1,0,0,10'h107,0,0);
    add(1,10'h108, 0,0,0,0,       0,0,     1,0,0,10'h108,0,0);
    add(0,0,     0,0,0,0,         0,0,     0,0,0,0,0,0);
    // test 5: button wins first tie, CPU write follows, readback
    add(0,0, 0,0,0,0,                 1,12'h3C3, 0,0,0,0,0,0);
    add(0,0, 1,1,10'h020,16'hBEEF,    0,0,       0,0,1,10'h3FF,16'h03C3,1);
    add(0,0, 1,1,10'h020,16'hBEEF,    0,0,       0,1,1,10'h020,16'hBEEF,0);
    add(0,0, 1,0,10'h020,0,           0,0,       0,1,0,10'h020,0,0);
    add(0,0, 0,0,0,0,                 0,0,       0,0,0,0,0,0);
    // round-robin: after a button grant the CPU wins the next tie
    add(0,0, 1,0,10'h011,0,           1,12'h111, 0,1,0,10'h011,0,0);
    add(0,0, 0,0,0,0,                 0,0,       0,0,1,10'h3FF,16'h0111,1);
    add(0,0, 0,0,0,0,                 1,12'h222, 0,0,0,0,0,0);
    add(0,0, 1,1,10'h030,16'h7777,    0,0,       0,1,1,10'h030,16'h7777,1);
    add(0,0, 0,0,0,0,                 0,0,       0,0,1,10'h3FF,16'h0222,1);
    // CPU write to the button word is arbitrated like any other access
    add(0,0, 1,1,10'h3FF,16'h1111,    0,0,       0,1,1,10'h3FF,16'h1111,0);
    // update in the same cycle as a button grant: old word written, new word kept pending
    add(0,0, 0,0,0,0,                 1,12'h0AA, 0,0,0,0,0,0);
    add(0,0, 0,0,0,0,                 1,12'h0BB, 0,0,1,10'h3FF,16'h00AA,1);
    add(0,0, 0,0,0,0,                 0,0,       0,0,1,10'h3FF,16'h00BB,1);
    add(0,0, 0,0,0,0,                 0,0,       0,0,0,0,0,0);

    // test 1: reset with requests and a button pulse present
    reset = 0;
    idle_inputs();
    vga_req = 1; vga_addr = 10'h005; cpu_req = 1; btn_update = 1; btn_data = 12'hFFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; #3;
      check("rst_gnt_we", {vga_gnt, cpu_gnt, mem_we_b}, 0);
      check("rst_mem_bus", {mem_addr_b, mem_data_b}, 0);
    end
    @(posedge clk); #1;
    reset = 1;
    idle_inputs();
    #3;
    check("post_rst_idle", {vga_gnt, cpu_gnt, mem_we_b, vga_rvalid, cpu_rvalid, btn_pending}, 0);
    check("post_rst_bus", {mem_addr_b, mem_data_b}, 0);

    // test 2: single VGA read
    @(posedge clk); #1;
    vga_req = 1; vga_addr = 10'h005;
    vga_q.push_back(ref_mem[5]);
    #3;
    check("vga_single_gnt", {vga_gnt, cpu_gnt, mem_we_b, mem_addr_b}, {3'b100, 10'h005});
    @(posedge clk); #1;
    idle_inputs();
    #3;
    check("vga_single_rvalid", {vga_rvalid, vga_rdata}, {1'b1, 16'h1234});

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(posedge clk); #1;
      vga_req = v.vreq; vga_addr = v.vaddr;
      cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwdata;
      btn_update = v.bupd; btn_data = v.bdata;
      if (v.e_vgnt) vga_q.push_back(ref_mem[v.vaddr]);
      if (v.e_cgnt && !v.cwe) cpu_q.push_back(ref_mem[v.caddr]);
      if (v.e_we) ref_mem[v.e_addr] = v.e_data;
      #3;
      check($sformatf("vec%0d", i),
            {vga_gnt, cpu_gnt, mem_we_b, mem_addr_b, mem_data_b, btn_pending},
            {v.e_vgnt, v.e_cgnt, v.e_we, v.e_addr, v.e_data, v.e_pend});
    end

    // test 6a: CPU read granted, reset the next cycle drops the return
    @(posedge clk); #1;
    idle_inputs();
    cpu_req = 1; cpu_addr = 10'h010;
    #3;
    check("rst_read_gnt", cpu_gnt, 1);
    @(posedge clk); #1;
    idle_inputs();
    reset = 0;
    #3;
    check("rst_read_rvalid_in_rst", cpu_rvalid, 0);
    @(posedge clk); #1;
    reset = 1;
    #3;
    check("rst_read_rvalid_after", cpu_rvalid, 0);

    // test 6b: two back-to-back button samples under VGA load give one write of the latest
    bw_count = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vga_req = 1; vga_addr = 10'h100;
      btn_update = (i < 2);
      btn_data = (i == 0) ? 12'h001 : 12'h002;
      ev = (i != 4);
      if (ev) vga_q.push_back(ref_mem[10'h100]);
      #3;
      if (mem_we_b && mem_addr_b == 10'h3FF) bw_count++;
      check($sformatf("vga_load_btn%0d", i),
            {vga_gnt, mem_we_b, mem_addr_b, mem_data_b},
            {ev, !ev, (ev ? 10'h100 : 10'h3FF), (ev ? 16'h0000 : 16'h0002)});
    end
    @(posedge clk); #1;
    idle_inputs();
    #3;
    check("btn_single_write", bw_count, 1);
    check("btn_pending_clear", btn_pending, 0);

    repeat (3) @(posedge clk);
    #4;
    check("vga_q_drained", vga_q.size(), 0);
    check("cpu_q_drained", cpu_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
